// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard. It tracks fixed-latency countdowns and variable-latency
// completions, and drives the decode stall. Optional statistics counters are enabled by SB_STATS_EN.
module reg_scoreboard #(
  parameter int LAT_W   = 3,
  parameter int MAX_VAR = 2
) (
  input  logic                         clk_core,
  input  logic                         reset_n,
  input  logic                         de_issue,
  input  logic [1:0]                   de_class,
  input  logic [LAT_W-1:0]             de_lat,
  input  logic [4:0]                   de_rd,
  input  logic [4:0]                   de_rs1,
  input  logic [4:0]                   de_rs2,
  input  logic                         de_use_rs1,
  input  logic                         de_use_rs2,
  input  logic                         de_chk_rd,
  input  logic [1:0]                   de_chk_class,
  input  logic                         kill,
  input  logic                         cmpl_valid,
  input  logic [4:0]                   cmpl_reg,
  output logic                         sb_stall,
  output logic [31:0]                  sb_busy,
  output logic [$clog2(MAX_VAR+1)-1:0] sb_var_cnt
`ifdef SB_STATS_EN
  ,
  output logic [31:0]                  sb_stall_cycles,
  output logic [15:0]                  sb_kill_events
`endif
);

  localparam int VCW = $clog2(MAX_VAR+1);

  typedef enum logic [1:0] {ST_IDLE, ST_FIX, ST_VAR} ent_state_t;

  logic             issue_ok;
  logic [LAT_W-1:0] lat_eff;
  logic [31:0]      busy_vec;
  logic [31:0]      young_vec;
  logic [31:0]      var_next_vec;
  logic [5:0]       var_pop;
  logic [VCW-1:0]   var_cnt_q, var_cnt_d;

  // A killed issue is never recorded, so the kill masks the issue here once for all entries.
  assign issue_ok = de_issue && (de_class == 2'd1 || de_class == 2'd2) && (de_rd != 5'd0) && !kill;
  assign lat_eff  = (de_lat == '0) ? LAT_W'(1) : de_lat;

  assign busy_vec[0]     = 1'b0;
  assign young_vec[0]    = 1'b0;
  assign var_next_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_ent
      ent_state_t       state_q, state_d;
      logic [LAT_W-1:0] cnt_q, cnt_d;
      logic             young_q, young_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        young_d = 1'b0;
        case (state_q)
          ST_FIX: begin
            if (cnt_q <= LAT_W'(1)) state_d = ST_IDLE;
            else                    cnt_d   = cnt_q - LAT_W'(1);
          end
          ST_VAR:  if (cmpl_valid && cmpl_reg == 5'(gi)) state_d = ST_IDLE;
          default: ;
        endcase
        if (kill && young_q) state_d = ST_IDLE;
        // A new issue overrides a same-cycle retirement of the previous writer.
        if (issue_ok && de_rd == 5'(gi)) begin
          young_d = 1'b1;
          if (de_class == 2'd1) begin
            state_d = ST_FIX;
            cnt_d   = lat_eff;
          end else begin
            state_d = ST_VAR;
          end
        end
      end

      always_ff @(posedge clk_core) begin
        if (!reset_n) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          young_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          young_q <= young_d;
        end
      end

      assign busy_vec[gi]     = (state_q != ST_IDLE);
      assign young_vec[gi]    = young_q;
      assign var_next_vec[gi] = (state_d == ST_VAR);
    end
  endgenerate

  always_comb begin
    var_pop = '0;
    for (int i = 0; i < 32; i++) var_pop = var_pop + {5'd0, var_next_vec[i]};
    var_cnt_d = (var_pop > 6'(MAX_VAR)) ? VCW'(MAX_VAR) : VCW'(var_pop);
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) var_cnt_q <= '0;
    else          var_cnt_q <= var_cnt_d;
  end

  assign sb_busy    = busy_vec;
  assign sb_var_cnt = var_cnt_q;

  always_comb begin
    sb_stall = 1'b0;
    if (de_use_rs1 && de_rs1 != 5'd0 && busy_vec[de_rs1]) sb_stall = 1'b1;
    if (de_use_rs2 && de_rs2 != 5'd0 && busy_vec[de_rs2]) sb_stall = 1'b1;
    if (de_chk_rd  && de_rd  != 5'd0 && busy_vec[de_rd])  sb_stall = 1'b1;
    if (de_chk_class == 2'd2 && var_cnt_q == VCW'(MAX_VAR)) sb_stall = 1'b1;
  end

`ifdef SB_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] kill_events_q, kill_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    kill_events_d  = kill_events_q;
    if (sb_stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 32'd1;
    if (kill && (|young_vec) && kill_events_q != '1) kill_events_d = kill_events_q + 16'd1;
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      kill_events_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      kill_events_q  <= kill_events_d;
    end
  end

  assign sb_stall_cycles = stall_cycles_q;
  assign sb_kill_events  = kill_events_q;
`else
  logic unused_young;
  assign unused_young = ^young_vec;
`endif

`ifndef SYNTHESIS
  issue_while_stalled: assert property (@(posedge clk_core) disable iff (!reset_n) !(de_issue && sb_stall))
    else $error("reg_scoreboard: de_issue asserted while sb_stall=1");
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a reference model pushes expected outputs every cycle, and a
// negedge monitor pops and compares them. The stats outputs are checked when SB_STATS_EN is defined.
module tb_reg_scoreboard;
  localparam int LAT_W   = 3;
  localparam int MAX_VAR = 2;
  localparam int VCW     = $clog2(MAX_VAR+1);

  logic             clk_core = 1'b0;
  logic             reset_n  = 1'b0;
  logic             de_issue, de_use_rs1, de_use_rs2, de_chk_rd, kill, cmpl_valid;
  logic [1:0]       de_class, de_chk_class;
  logic [LAT_W-1:0] de_lat;
  logic [4:0]       de_rd, de_rs1, de_rs2, cmpl_reg;
  logic             sb_stall;
  logic [31:0]      sb_busy;
  logic [VCW-1:0]   sb_var_cnt;
`ifdef SB_STATS_EN
  logic [31:0]      sb_stall_cycles;
  logic [15:0]      sb_kill_events;
`endif

  always #5 clk_core = ~clk_core;

  reg_scoreboard #(.LAT_W(LAT_W), .MAX_VAR(MAX_VAR)) dut (
    .clk_core(clk_core), .reset_n(reset_n), .de_issue(de_issue), .de_class(de_class),
    .de_lat(de_lat), .de_rd(de_rd), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_chk_rd(de_chk_rd),
    .de_chk_class(de_chk_class), .kill(kill), .cmpl_valid(cmpl_valid), .cmpl_reg(cmpl_reg),
    .sb_stall(sb_stall), .sb_busy(sb_busy), .sb_var_cnt(sb_var_cnt)
`ifdef SB_STATS_EN
    , .sb_stall_cycles(sb_stall_cycles), .sb_kill_events(sb_kill_events)
`endif
  );

  typedef struct {
    logic [31:0] busy;
    int          vcnt;
    logic        stall;
    int          stall_cycles;
    int          kill_events;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: remaining busy cycles for fixed writes, a pending flag for variable writes.
  int   rem[32];
  bit   vpend[32];
  bit   yng[32];
  int   m_stall_cycles = 0;
  int   m_kill_events  = 0;
  bit   cur_stall;

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (rem[r] > 0) || vpend[r];
    return b;
  endfunction

  function automatic int m_vcnt();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(vpend[r]);
    return n;
  endfunction

  function automatic bit m_stall();
    logic [31:0] b = m_busy();
    bit s = 0;
    if (de_use_rs1 && de_rs1 != 0 && b[de_rs1]) s = 1;
    if (de_use_rs2 && de_rs2 != 0 && b[de_rs2]) s = 1;
    if (de_chk_rd && de_rd != 0 && b[de_rd]) s = 1;
    if (de_chk_class == 2 && m_vcnt() == MAX_VAR) s = 1;
    return s;
  endfunction

  task automatic model_update();
    bit any_young = 0;
    bit take;
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin rem[r] = 0; vpend[r] = 0; yng[r] = 0; end
      m_stall_cycles = 0;
      m_kill_events  = 0;
      return;
    end
    for (int r = 0; r < 32; r++) any_young |= yng[r];
    if (cur_stall) m_stall_cycles++;
    if (kill && any_young && m_kill_events < 65535) m_kill_events++;
    take = de_issue && (de_class == 1 || de_class == 2) && de_rd != 0 && !kill;
    for (int r = 1; r < 32; r++) begin
      if (rem[r] > 0) rem[r]--;
      if (vpend[r] && cmpl_valid && cmpl_reg == r) vpend[r] = 0;
      if (kill && yng[r]) begin rem[r] = 0; vpend[r] = 0; end
      yng[r] = 0;
      if (take && de_rd == r) begin
        yng[r] = 1;
        if (de_class == 1) begin rem[r] = (de_lat == 0) ? 1 : int'(de_lat); vpend[r] = 0; end
        else begin vpend[r] = 1; rem[r] = 0; end
      end
    end
  endtask

  task automatic idle_inputs();
    de_issue = 0; de_class = 0; de_lat = 0; de_rd = 0; de_rs1 = 0; de_rs2 = 0;
    de_use_rs1 = 0; de_use_rs2 = 0; de_chk_rd = 0; de_chk_class = 0;
    kill = 0; cmpl_valid = 0; cmpl_reg = 0;
  endtask

  // Record the expectation for the inputs currently driven, then advance one clock.
  task automatic tick();
    exp_t e;
    cur_stall      = m_stall();
    e.busy         = m_busy();
    e.vcnt         = m_vcnt();
    e.stall        = cur_stall;
    e.stall_cycles = m_stall_cycles;
    e.kill_events  = m_kill_events;
    exp_q.push_back(e);
    @(posedge clk_core);
    model_update();
    #1;
    idle_inputs();
    reset_n = 1'b1;
  endtask

  task automatic issue(input int cls, input int rd, input int lat);
    de_issue = 1; de_class = 2'(cls); de_rd = 5'(rd); de_lat = LAT_W'(lat); de_chk_class = 2'(cls);
  endtask

  task automatic cmp(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_core);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("sb_busy", longint'(sb_busy), longint'(e.busy));
        cmp("sb_var_cnt", longint'(sb_var_cnt), longint'(e.vcnt));
        cmp("sb_stall", longint'(sb_stall), longint'(e.stall));
`ifdef SB_STATS_EN
        cmp("sb_stall_cycles", longint'(sb_stall_cycles), longint'(e.stall_cycles));
        cmp("sb_kill_events", longint'(sb_kill_events), longint'(e.kill_events));
`endif
      end
    end
  end

  initial begin : stim
    idle_inputs();
    for (int r = 0; r < 32; r++) begin rem[r] = 0; vpend[r] = 0; yng[r] = 0; end
    reset_n = 1'b0;
    repeat (2) @(posedge clk_core);
    #1;
    reset_n = 1'b0;
    tick();                                  // reset state

    // Fixed latency 3 on x5 with a dependent reader probing the stall.
    issue(1, 5, 3); tick();
    for (int c = 1; c <= 5; c++) begin de_use_rs1 = 1; de_rs1 = 5; tick(); end

    // Two variable entries fill the table; completing x7 frees a slot.
    issue(2, 7, 0); tick();
    issue(2, 9, 0); tick();
    de_chk_class = 2; tick();
    cmpl_valid = 1; cmpl_reg = 7; de_chk_class = 2; tick();
    de_chk_class = 2; tick();
    cmpl_valid = 1; cmpl_reg = 9; tick();

    // Kill squashes only the youngest issue.
    issue(1, 4, 5); tick();
    issue(2, 3, 0); tick();
    kill = 1; tick();
    repeat (5) tick();

    // Kill coinciding with an issue drops the issue.
    issue(2, 6, 0); kill = 1; tick();
    tick();

    // Same-register completion and reissue.
    issue(2, 10, 0); tick();
    tick();
    issue(2, 10, 0); cmpl_valid = 1; cmpl_reg = 10; tick();
    tick();
    cmpl_valid = 1; cmpl_reg = 10; tick();

    // Kill of a young variable entry racing its own completion.
    issue(2, 14, 0); tick();
    kill = 1; cmpl_valid = 1; cmpl_reg = 14; tick();
    tick();

    // x0 never tracked; latency 0 behaves as latency 1.
    issue(1, 0, 4); tick();
    issue(1, 2, 0); tick();
    tick(); tick();

    // Reset with three entries pending.
    issue(1, 11, 7); tick();
    issue(2, 12, 0); tick();
    issue(2, 13, 0); tick();
    de_use_rs1 = 1; de_rs1 = 11; reset_n = 1'b0; tick();
    de_use_rs1 = 1; de_rs1 = 11; de_chk_class = 2; tick();

    // Randomized traffic with occasional kills, completions and resets.
    for (int i = 0; i < 600; i++) begin
      de_class     = 2'($urandom_range(0, 3));
      de_lat       = LAT_W'($urandom_range(0, 7));
      de_rd        = 5'($urandom_range(0, 15));
      de_rs1       = 5'($urandom_range(0, 15));
      de_rs2       = 5'($urandom_range(0, 15));
      de_use_rs1   = 1'($urandom_range(0, 1));
      de_use_rs2   = 1'($urandom_range(0, 1));
      de_chk_rd    = 1'b1;
      de_chk_class = de_class;
      kill         = ($urandom_range(0, 9) == 0);
      cmpl_valid   = ($urandom_range(0, 2) == 0);
      cmpl_reg     = 5'($urandom_range(0, 15));
      de_issue     = ($urandom_range(0, 1) == 1) && !m_stall();
      if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
      tick();
    end

    @(negedge clk_core);
    #1;
    cmp("queue_drained", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register pending-write tracker for the integer pipeline.
- Records destination registers of long-latency instructions at decode issue: fixed-latency multiplies and variable-latency loads and CSR reads.
- Produces a decode stall when a source or destination register is still pending.
- Retires entries by countdown (fixed latency) or by a completion strobe from memory1 or writeback (variable latency). Entries squashed by a pipeline kill are cleared.

Parameters:
- LAT_W, 3, width of the fixed-latency countdown; max latency 2^LAT_W-1.
- MAX_VAR, 2, maximum simultaneous variable-latency entries.

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- de_issue  in  1  decode instruction leaves decode this cycle (de_valid & ~de_stall)
- de_class  in  2  0=untracked, 1=fixed latency, 2=variable latency, 3=reserved (treated as 0)
- de_lat  in  LAT_W  latency for class 1
- de_rd  in  5  destination register of issuing instruction
- de_rs1  in  5  decode source 1
- de_rs2  in  5  decode source 2
- de_use_rs1  in  1  rs1 is read by decode instruction
- de_use_rs2  in  1  rs2 is read by decode instruction
- de_chk_rd  in  1  decode instruction writes rd (WAW check)
- de_chk_class  in  2  class of instruction currently in decode (for full check)
- kill  in  1  csr_kill | ex_br_miss; squashes youngest issue
- cmpl_valid  in  1  variable-latency result written
- cmpl_reg  in  5  register completed
- sb_stall  out  1  decode must stall
- sb_busy  out  32  pending bit per register; bit 0 always 0
- sb_var_cnt  out  $clog2(MAX_VAR+1)  outstanding variable entries

Behaviour:
- Reset is synchronous on reset_n=0: all entries IDLE, sb_busy=0, sb_var_cnt=0, sb_stall=0, counters 0. Reset mid-operation discards all entries.
- Per-register state is one of IDLE, FIX (countdown cnt), or VAR. A separate young flag is set only in the cycle after issue.
- Issue (de_issue & class∈{1,2} & de_rd≠0):
  - Next cycle the entry is FIX with cnt=max(de_lat,1), or VAR; young=1.
  - x0 is never tracked. Class 0/3 issues are ignored.
- FIX countdown:
  - cnt decrements every cycle starting the cycle after issue.
  - In the cycle cnt==1 the entry returns to IDLE at the clock edge.
  - With de_lat=L, sb_busy[rd]=1 for exactly L cycles after the issue edge.
- VAR: the entry returns to IDLE at the edge where cmpl_valid & cmpl_reg==reg. cmpl on an IDLE or FIX register is ignored.
- young clears after one cycle.
- kill:
  - Every entry with young=1 returns to IDLE at the edge; sb_var_cnt is decremented accordingly.
  - An issue coinciding with kill is not recorded.
  - Older entries are unaffected.
- Simultaneous issue and completion on the same register: the new issue wins and the entry stays busy. The var count nets to unchanged when both are VAR.
- Simultaneous kill of a young VAR entry and cmpl of the same register: the entry goes IDLE and the count decrements once.
- sb_var_cnt counts VAR entries. It never exceeds MAX_VAR and never underflows.
- sb_stall (combinational) is the OR of:
  - de_use_rs1 & busy[de_rs1]
  - de_use_rs2 & busy[de_rs2]
  - de_chk_rd & busy[de_rd]
  - de_chk_class==2 & sb_var_cnt==MAX_VAR
- The rs1/rs2/rd stall terms are masked when the register is x0.
- The stall uses current busy only, not same-cycle completions (no bypass; one-cycle conservative).
- Issue while sb_stall=1 is illegal. The sim-only check prints an error.

Optional Feature:
- Macro SB_STATS_EN.
- When defined:
  - Adds outputs sb_stall_cycles (32 bits) and sb_kill_events (16 bits), both saturating counters reset to 0 by reset_n.
  - sb_stall_cycles increments every cycle sb_stall=1.
  - sb_kill_events increments on each kill that clears ≥1 entry.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Fixed-latency timing: issue class1, rd=5, lat=3 at cycle 0. Expect:
  - sb_busy[5]=1 on cycles 1–3 and 0 on cycle 4.
  - de_use_rs1 with rs1=5 gives sb_stall=1 on cycles 1–3 only.
- VAR completion and full check, MAX_VAR=2: issue VAR rd=7 and rd=9.
  - sb_var_cnt=2; de_chk_class=2 gives sb_stall=1.
  - cmpl_reg=7 clears bit 7, then sb_var_cnt=1 and the stall drops.
- Kill: issue VAR rd=3, then assert kill the next cycle.
  - Entry 3 returns to IDLE and sb_var_cnt returns to 0.
  - An entry issued 2 cycles earlier (rd=4, lat=5) stays busy.
- Same-register collision: VAR rd=10 pending; same cycle cmpl_reg=10 and new issue VAR rd=10 → busy[10] stays 1 and sb_var_cnt unchanged.
- x0 and latency 0: issue class1 rd=0 → sb_busy=0. Issue class1 rd=2, lat=0 → busy[2]=1 for exactly 1 cycle.
- Reset mid-operation: reset_n=0 with 3 entries pending → next cycle all busy=0, sb_var_cnt=0, sb_stall=0.
  - With SB_STATS_EN: stats counters are also 0.
